uart_reader: RTL and testbench

- Counterpart to the debugger's UART transmit-side word splitter.
- Pops UART_BUS_SIZE-wide bytes from the UART RX FIFO and assembles OUT_BUS_SIZE/UART_BUS_SIZE of them into one wide word. Byte 0 lands in the LSBs, matching the transmit-side ordering.
- Used by the debugger command/data path to receive wide words from the host.
- Optional inactivity timeout aborts a stalled read.

---
 rtl/uart_reader_pkg.sv | 14 +
 rtl/uart_reader.sv | 145 ++++++++++++++
 tb/tb_uart_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reader_pkg.sv
// Shared defaults and state encoding for the UART RX word assembler.
package uart_reader_pkg;

  localparam int DEFAULT_UART_READER_BUS_SIZE     = 8;
  localparam int DEFAULT_UART_READER_OUT_BUS_SIZE = 32;
  localparam int DEFAULT_UART_READER_TIMEOUT      = 0;

  typedef enum logic [1:0] {
    UART_READER_STATE_IDLE    = 2'd0,
    UART_READER_STATE_RD_WAIT = 2'd1,
    UART_READER_STATE_RD      = 2'd2
  } uart_reader_state_t;

endpackage

// File: rtl/uart_reader.sv
// Pops bytes from a first-word-fall-through RX FIFO and assembles them,
// byte 0 in the LSBs, into one wide word; an optional timeout aborts stalls.
module uart_reader
  import uart_reader_pkg::*;
#(
  parameter int UART_BUS_SIZE  = DEFAULT_UART_READER_BUS_SIZE,
  parameter int OUT_BUS_SIZE   = DEFAULT_UART_READER_OUT_BUS_SIZE,
  parameter int TIMEOUT_CYCLES = DEFAULT_UART_READER_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_uart_empty,
  input  logic [UART_BUS_SIZE-1:0] i_uart_data_rd,
  input  logic                     i_start_rd,
  output logic                     o_uart_rd,
  output logic                     o_rd_end,
  output logic                     o_rd_timeout,
  output logic [OUT_BUS_SIZE-1:0]  o_rd_data
);

  localparam int N     = OUT_BUS_SIZE / UART_BUS_SIZE;
  localparam int PTR_W = $clog2(N) + 1;

  uart_reader_state_t      r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_ptr, w_ptr_nxt;
  logic [OUT_BUS_SIZE-1:0] r_shadow, w_shadow_nxt;
  logic [OUT_BUS_SIZE-1:0] r_rd_data, w_rd_data_nxt;
  logic                    r_uart_rd, w_uart_rd_nxt;
  logic                    r_rd_end, w_rd_end_nxt;
  logic                    r_rd_timeout, w_rd_timeout_nxt;

  logic w_start_acc;
  logic w_ptr_done;
  logic w_pop;
  logic w_wait_empty;
  logic w_timeout_hit;

  assign w_start_acc  = (r_state == UART_READER_STATE_IDLE) && i_start_rd;
  assign w_ptr_done   = (r_ptr == PTR_W'(N));
  assign w_pop        = (r_state == UART_READER_STATE_RD_WAIT) && !w_ptr_done && !i_uart_empty;
  assign w_wait_empty = (r_state == UART_READER_STATE_RD_WAIT) && !w_ptr_done && i_uart_empty;

  // Saturating count of consecutive empty-FIFO waits; cleared on start and on each pop.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_last;

    assign w_cnt_last    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout_hit = w_wait_empty && w_cnt_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_cnt <= '0;
      end else if (w_start_acc || w_pop) begin
        r_cnt <= '0;
      end else if (w_wait_empty && !w_cnt_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end else begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= UART_READER_STATE_IDLE;
      r_ptr        <= '0;
      r_shadow     <= '0;
      r_rd_data    <= '0;
      r_uart_rd    <= 1'b0;
      r_rd_end     <= 1'b0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_shadow     <= w_shadow_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_uart_rd    <= w_uart_rd_nxt;
      r_rd_end     <= w_rd_end_nxt;
      r_rd_timeout <= w_rd_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UART_READER_STATE_IDLE: begin
        if (i_start_rd) w_state_nxt = UART_READER_STATE_RD_WAIT;
      end
      UART_READER_STATE_RD_WAIT: begin
        if (w_ptr_done)         w_state_nxt = UART_READER_STATE_IDLE;
        else if (!i_uart_empty) w_state_nxt = UART_READER_STATE_RD;
        else if (w_timeout_hit) w_state_nxt = UART_READER_STATE_IDLE;
      end
      UART_READER_STATE_RD: w_state_nxt = UART_READER_STATE_RD_WAIT;
      default:              w_state_nxt = UART_READER_STATE_IDLE;
    endcase
  end

  // The pop strobe lasts one cycle; the following RD cycle lets the FIFO flag settle.
  always_comb begin
    w_ptr_nxt        = r_ptr;
    w_shadow_nxt     = r_shadow;
    w_rd_data_nxt    = r_rd_data;
    w_uart_rd_nxt    = 1'b0;
    w_rd_end_nxt     = r_rd_end;
    w_rd_timeout_nxt = r_rd_timeout;
    case (r_state)
      UART_READER_STATE_IDLE: begin
        if (i_start_rd) begin
          w_rd_end_nxt     = 1'b0;
          w_rd_timeout_nxt = 1'b0;
        end
      end
      UART_READER_STATE_RD_WAIT: begin
        if (w_ptr_done) begin
          w_rd_data_nxt = r_shadow;
          w_rd_end_nxt  = 1'b1;
          w_ptr_nxt     = '0;
        end else if (!i_uart_empty) begin
          for (int b = 0; b < N; b++) begin
            if (r_ptr == PTR_W'(b)) w_shadow_nxt[b*UART_BUS_SIZE +: UART_BUS_SIZE] = i_uart_data_rd;
          end
          w_uart_rd_nxt = 1'b1;
        end else if (w_timeout_hit) begin
          w_rd_timeout_nxt = 1'b1;
          w_ptr_nxt        = '0;
        end
      end
      UART_READER_STATE_RD: begin
        w_ptr_nxt = r_ptr + PTR_W'(1);
      end
      default: begin
        w_ptr_nxt = '0;
      end
    endcase
  end

  assign o_uart_rd    = r_uart_rd;
  assign o_rd_end     = r_rd_end;
  assign o_rd_timeout = r_rd_timeout;
  assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_uart_reader.sv
// Bench for uart_reader: three instances (N=4 no timeout, N=4 timeout 16, N=1)
// each fed by a small FIFO model that is updated on the falling clock edge.
module tb_uart_reader;

  logic       clk;
  logic       rst;
  logic       empty [3];
  logic [7:0] din   [3];
  logic       start [3];
  logic       urd   [3];
  logic       rd_end [3];
  logic       rd_to  [3];
  logic [31:0] rdata0, rdata1;
  logic [7:0]  rdata2;

  uart_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(32), .TIMEOUT_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_uart_empty(empty[0]), .i_uart_data_rd(din[0]),
    .i_start_rd(start[0]), .o_uart_rd(urd[0]), .o_rd_end(rd_end[0]),
    .o_rd_timeout(rd_to[0]), .o_rd_data(rdata0));

  uart_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(32), .TIMEOUT_CYCLES(16)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_uart_empty(empty[1]), .i_uart_data_rd(din[1]),
    .i_start_rd(start[1]), .o_uart_rd(urd[1]), .o_rd_end(rd_end[1]),
    .o_rd_timeout(rd_to[1]), .o_rd_data(rdata1));

  uart_reader #(.UART_BUS_SIZE(8), .OUT_BUS_SIZE(8), .TIMEOUT_CYCLES(0)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_uart_empty(empty[2]), .i_uart_data_rd(din[2]),
    .i_start_rd(start[2]), .o_uart_rd(urd[2]), .o_rd_end(rd_end[2]),
    .o_rd_timeout(rd_to[2]), .o_rd_data(rdata2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          inst;
    logic [31:0] word;
    int          nb;
    int          gpos;
    int          glen;
    logic [31:0] exp;
    int          exp_e;
  } vec_t;

  logic [7:0] q [3][$];
  int pop_cnt [3];
  int gap_pos [3];
  int gap_len [3];
  int gap_cnt [3];
  int checks;
  int errors;

  function automatic logic [31:0] get_data(input int i);
    if (i == 0) return rdata0;
    if (i == 1) return rdata1;
    return {24'h0, rdata2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      empty[i] = (q[i].size() == 0) || (gap_cnt[i] > 0);
      din[i]   = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  // One clock: service pops seen since the last falling edge, then refresh FIFO outputs.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (gap_cnt[i] > 0) gap_cnt[i]--;
      if (urd[i] === 1'b1) begin
        chk("pop_while_empty", {31'h0, empty[i]}, 32'h0);
        if (q[i].size() > 0) void'(q[i].pop_front());
        pop_cnt[i]++;
        if (gap_len[i] > 0 && pop_cnt[i] == gap_pos[i]) gap_cnt[i] = gap_len[i] + 1;
      end
    end
    drive();
  endtask

  task automatic push_word(input int i, input logic [31:0] w, input int nb);
    for (int b = 0; b < nb; b++) q[i].push_back(w[8*b +: 8]);
    drive();
  endtask

  // Starts a read and returns the edge (0 = edge that sampled start) where o_rd_end rose.
  task automatic do_read(input int i, input logic [31:0] w, input int nb,
                         input int gpos, input int glen, output int end_e);
    int e;
    pop_cnt[i] = 0;
    gap_pos[i] = gpos;
    gap_len[i] = glen;
    push_word(i, w, nb);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    e = 0;
    end_e = -1;
    while (end_e < 0 && e < 200) begin
      if (rd_end[i] === 1'b1) end_e = e;
      else begin
        tick();
        e++;
      end
    end
  endtask

  vec_t vecs [5];
  int   end_e;
  int   e;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; pop_cnt[i] = 0; gap_pos[i] = 0; gap_len[i] = 0; gap_cnt[i] = 0;
    end
    drive();

    vecs[0] = '{0, 32'h44332211, 4, 0, 0, 32'h44332211, 9};
    vecs[1] = '{0, 32'h44332211, 4, 2, 5, 32'h44332211, 14};
    vecs[2] = '{0, 32'h807F01FE, 4, 0, 0, 32'h807F01FE, 9};
    vecs[3] = '{2, 32'h0000005A, 1, 0, 0, 32'h0000005A, 3};
    vecs[4] = '{1, 32'h44332211, 4, 0, 0, 32'h44332211, 9};

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_uart_rd", {31'h0, urd[i]}, 32'h0);
      chk("reset_rd_end", {31'h0, rd_end[i]}, 32'h0);
      chk("reset_rd_timeout", {31'h0, rd_to[i]}, 32'h0);
      chk("reset_rd_data", get_data(i), 32'h0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      do_read(vecs[v].inst, vecs[v].word, vecs[v].nb, vecs[v].gpos, vecs[v].glen, end_e);
      chk($sformatf("v%0d_latency", v), end_e, vecs[v].exp_e);
      chk($sformatf("v%0d_data", v), get_data(vecs[v].inst), vecs[v].exp);
      chk($sformatf("v%0d_pops", v), pop_cnt[vecs[v].inst], vecs[v].nb);
      chk($sformatf("v%0d_timeout", v), {31'h0, rd_to[vecs[v].inst]}, 32'h0);
      tick();
      tick();
      chk($sformatf("v%0d_end_held", v), {31'h0, rd_end[vecs[v].inst]}, 32'h1);
      chk($sformatf("v%0d_no_extra_pop", v), pop_cnt[vecs[v].inst], vecs[v].nb);
    end

    // Timeout: only two bytes arrive after the earlier word on instance 1.
    pop_cnt[1] = 0;
    gap_len[1] = 0;
    push_word(1, 32'h0000BBAA, 2);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("to_end_cleared", {31'h0, rd_end[1]}, 32'h0);
    e = 0;
    while (rd_to[1] !== 1'b1 && e < 100) begin
      tick();
      e++;
    end
    chk("to_edge", e, 20);
    chk("to_rd_end", {31'h0, rd_end[1]}, 32'h0);
    chk("to_data_kept", rdata1, 32'h44332211);
    chk("to_pops", pop_cnt[1], 2);
    tick();
    tick();
    chk("to_held", {31'h0, rd_to[1]}, 32'h1);

    // Restart pulses during a read are ignored; the next read starts only on a new start.
    pop_cnt[0] = 0;
    gap_len[0] = 0;
    push_word(0, 32'h44332211, 4);
    push_word(0, 32'hDDCCBBAA, 4);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    e = 0;
    while (rd_end[0] !== 1'b1 && e < 100) begin
      start[0] = (e == 3 || e == 5);
      tick();
      e++;
    end
    start[0] = 1'b0;
    chk("rp_first_edge", e, 9);
    chk("rp_first_data", rdata0, 32'h44332211);
    chk("rp_first_pops", pop_cnt[0], 4);
    for (int k = 0; k < 4; k++) tick();
    chk("rp_no_queued_read", pop_cnt[0], 4);
    chk("rp_end_held", {31'h0, rd_end[0]}, 32'h1);
    pop_cnt[0] = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("rp_end_drop", {31'h0, rd_end[0]}, 32'h0);
    e = 0;
    while (rd_end[0] !== 1'b1 && e < 100) begin
      tick();
      e++;
    end
    chk("rp_second_edge", e, 9);
    chk("rp_second_data", rdata0, 32'hDDCCBBAA);
    chk("rp_second_pops", pop_cnt[0], 4);

    // Asynchronous reset while the pop strobe is high.
    pop_cnt[0] = 0;
    push_word(0, 32'h04030201, 4);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("ar_pre_uart_rd", {31'h0, urd[0]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_uart_rd", {31'h0, urd[0]}, 32'h0);
    chk("ar_rd_end", {31'h0, rd_end[0]}, 32'h0);
    chk("ar_rd_data", rdata0, 32'h0);
    chk("ar_other_timeout", {31'h0, rd_to[1]}, 32'h0);
    chk("ar_other_data", rdata1, 32'h0);
    #1 rst = 1'b0;
    q[0].delete();
    drive();
    tick();
    tick();
    do_read(0, 32'h55667788, 4, 0, 0, end_e);
    chk("ar_after_latency", end_e, 9);
    chk("ar_after_data", rdata0, 32'h55667788);
    chk("ar_after_pops", pop_cnt[0], 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
